// File: rtl/gamma_stdp_sched_if.sv
// Bundle of signals between the gamma scheduler, the comparator array
// and the neuron datapath. The scheduler sits on the slave side. The
// master side drives run and the comparator results.
interface gamma_stdp_sched_if #(
   parameter int N_SYN = 8,
   parameter int WL    = 3
);
   logic                  run;
   logic [7*N_SYN-1:0]    prob_in;
   logic [N_SYN-1:0]      inc_in;
   logic                  cmp_rst_b;
   logic [WL*N_SYN-1:0]   weights;
   logic                  busy;
   logic                  upd_done;

   modport master (
      output run, prob_in, inc_in,
      input  cmp_rst_b, weights, busy, upd_done
   );

   modport slave (
      input  run, prob_in, inc_in,
      output cmp_rst_b, weights, busy, upd_done
   );
endinterface

// File: rtl/gamma_stdp_sched.sv
// Gamma-cycle scheduler for the LFSR-comparator STDP datapath.
// It frames each gamma window through the shared active-low comparator
// reset. It latches the first nonzero (prob, inc) result per comparator
// during the window and its closing cycle. It then walks the synapses one
// per cycle, applying a stochastic saturating +/-1 weight update whenever
// the shared LFSR value falls below the captured probability.
module gamma_stdp_sched #(
   parameter int             N_SYN     = 8,
   parameter int             GAMMA_LEN = 16,
   parameter int             WL        = 3,
   parameter logic [WL-1:0]  W_INIT    = WL'(4),
   parameter logic [6:0]     LFSR_SEED = 7'h01
) (
   input  logic               clk,
   input  logic               rst,
   gamma_stdp_sched_if.slave  bus
);

   localparam int            CW   = $clog2(GAMMA_LEN);
   localparam int            IW   = (N_SYN > 1) ? $clog2(N_SYN) : 1;
   localparam logic [WL-1:0] WMAX = {WL{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WINDOW = 2'd1,
      S_CLOSE  = 2'd2,
      S_UPDATE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [N_SYN-1:0]          cap_vld_q, cap_vld_d;
   logic [N_SYN-1:0][6:0]     cap_prob_q, cap_prob_d;
   logic [N_SYN-1:0]          cap_inc_q, cap_inc_d;
   logic [6:0]                lfsr_q, lfsr_d;
   logic [N_SYN-1:0][WL-1:0]  w_q, w_d;
   logic                      upd_done_q, upd_done_d;

   // Increment that sticks at the top of the weight range instead of wrapping.
   function automatic logic [WL-1:0] sat_inc(input logic [WL-1:0] w);
      return (w == WMAX) ? w : w + WL'(1);
   endfunction

   // Decrement that sticks at zero instead of wrapping.
   function automatic logic [WL-1:0] sat_dec(input logic [WL-1:0] w);
      return (w == '0) ? w : w - WL'(1);
   endfunction

   // One step of the x^7+x^6+1 Fibonacci LFSR. A nonzero seed never reaches 0.
   function automatic logic [6:0] lfsr_step(input logic [6:0] r);
      return {r[5:0], r[6] ^ r[5]};
   endfunction

   // Next-state, capture and weight-update logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      cap_vld_d  = cap_vld_q;
      cap_prob_d = cap_prob_q;
      cap_inc_d  = cap_inc_q;
      lfsr_d     = lfsr_q;
      w_d        = w_q;
      upd_done_d = 1'b0;

      // The first nonzero result from each comparator wins. Later ones are dropped.
      if (state_q == S_WINDOW || state_q == S_CLOSE) begin
         for (int i = 0; i < N_SYN; i++) begin
            if (!cap_vld_q[i] && (bus.prob_in[7*i +: 7] != 7'd0)) begin
               cap_vld_d[i]  = 1'b1;
               cap_prob_d[i] = bus.prob_in[7*i +: 7];
               cap_inc_d[i]  = bus.inc_in[i];
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.run) begin
               state_d   = S_WINDOW;
               cnt_d     = '0;
               cap_vld_d = '0;
            end
         end
         S_WINDOW: begin
            if (cnt_q == CW'(GAMMA_LEN - 1)) begin
               state_d = S_CLOSE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_CLOSE: begin
            state_d = S_UPDATE;
            idx_d   = '0;
         end
         S_UPDATE: begin
            // The LFSR advances every update slot, applied or not.
            lfsr_d = lfsr_step(lfsr_q);
            if (cap_vld_q[idx_q] && (lfsr_q < cap_prob_q[idx_q])) begin
               w_d[idx_q] = cap_inc_q[idx_q] ? sat_inc(w_q[idx_q]) : sat_dec(w_q[idx_q]);
            end
            if (idx_q == IW'(N_SYN - 1)) begin
               upd_done_d = 1'b1;
               idx_d      = '0;
               cnt_d      = '0;
               if (bus.run) begin
                  state_d   = S_WINDOW;
                  cap_vld_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers. Reset discards any partially completed window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         cap_vld_q  <= '0;
         cap_prob_q <= '0;
         cap_inc_q  <= '0;
         lfsr_q     <= LFSR_SEED;
         w_q        <= {N_SYN{W_INIT}};
         upd_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         cap_vld_q  <= cap_vld_d;
         cap_prob_q <= cap_prob_d;
         cap_inc_q  <= cap_inc_d;
         lfsr_q     <= lfsr_d;
         w_q        <= w_d;
         upd_done_q <= upd_done_d;
      end
   end

   assign bus.cmp_rst_b = (state_q == S_WINDOW);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.weights   = w_q;
   assign bus.upd_done  = upd_done_q;

endmodule

// File: tb/tb_gamma_stdp_sched.sv
// Testbench for gamma_stdp_sched: a stimulus thread plays gamma windows
// and pushes the expected weight vector for each window into a queue. A
// monitor thread pops the queue on every upd_done pulse and also checks
// comparator-reset framing and window period.
module tb_gamma_stdp_sched;

   localparam int N   = 8;
   localparam int GL  = 16;
   localparam int WL  = 3;
   localparam int WIN = GL + 1;

   logic clk;
   logic rst;

   gamma_stdp_sched_if #(.N_SYN(N), .WL(WL)) bus_if ();

   gamma_stdp_sched #(
      .N_SYN(N), .GAMMA_LEN(GL), .WL(WL), .W_INIT(3'd4), .LFSR_SEED(7'h01)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          seq[127];
   int          pos;
   int          m_w[N];
   logic [WL*N-1:0] exp_q[$];

   // Per-window stimulus: cycles 0..GL-1 are WINDOW, cycle GL is CLOSE
   int ev_prob[WIN][N];
   bit ev_inc[WIN][N];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int w_of(input int i);
      return int'(bus_if.weights[WL*i +: WL]);
   endfunction

   task automatic clear_ev();
      for (int c = 0; c < WIN; c++)
         for (int i = 0; i < N; i++) begin
            ev_prob[c][i] = 0;
            ev_inc[c][i]  = 1'b0;
         end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_w[i] = 4;
      pos = 0;
   endtask

   task automatic start_run();
      bus_if.prob_in = '0;
      bus_if.inc_in  = '0;
      bus_if.run     = 1'b1;
      @(posedge clk); #1;
   endtask

   // Plays one window from WINDOW cycle 0 through the last UPDATE cycle.
   // abort_u >= 0 asserts reset during that update slot instead of finishing.
   task automatic do_window(input bit keep_run, input int abort_u);
      int cap_p[N];
      bit cap_i[N];
      bit cap_v[N];
      int r;
      logic [WL*N-1:0] e;
      for (int c = 0; c < WIN; c++) begin
         for (int i = 0; i < N; i++) begin
            bus_if.prob_in[7*i +: 7] = 7'(ev_prob[c][i]);
            bus_if.inc_in[i]         = ev_inc[c][i];
         end
         @(posedge clk); #1;
      end
      // Expected outcome: first event per synapse, then one LFSR draw per synapse
      for (int i = 0; i < N; i++) begin
         cap_v[i] = 1'b0; cap_p[i] = 0; cap_i[i] = 1'b0;
      end
      for (int c = 0; c < WIN; c++)
         for (int i = 0; i < N; i++)
            if (!cap_v[i] && ev_prob[c][i] != 0) begin
               cap_v[i] = 1'b1; cap_p[i] = ev_prob[c][i]; cap_i[i] = ev_inc[c][i];
            end
      for (int i = 0; i < N; i++) begin
         r   = seq[pos];
         pos = (pos + 1) % 127;
         if (cap_v[i] && r < cap_p[i]) begin
            if (cap_i[i]) m_w[i] = (m_w[i] < 7) ? m_w[i] + 1 : 7;
            else          m_w[i] = (m_w[i] > 0) ? m_w[i] - 1 : 0;
         end
      end
      for (int i = 0; i < N; i++) e[WL*i +: WL] = 3'(m_w[i]);
      exp_q.push_back(e);
      for (int u = 0; u < N; u++) begin
         // Comparator outputs outside the window must be ignored
         bus_if.prob_in = 56'({$urandom, $urandom});
         bus_if.inc_in  = 8'($urandom);
         bus_if.run     = keep_run;
         if (u == abort_u) begin
            bus_if.run = 1'b0;
            rst = 1'b1;
            #1;
            for (int i = 0; i < N; i++) chk($sformatf("abort weight%0d", i), w_of(i), 4);
            chk("abort cmp_rst_b", int'(bus_if.cmp_rst_b), 0);
            chk("abort busy", int'(bus_if.busy), 0);
            chk("abort upd_done", int'(bus_if.upd_done), 0);
            void'(exp_q.pop_back());
            model_reset();
            @(posedge clk); #1;
            rst = 1'b0;
            bus_if.prob_in = '0;
            bus_if.inc_in  = '0;
            return;
         end
         @(posedge clk); #1;
      end
      bus_if.prob_in = '0;
      bus_if.inc_in  = '0;
   endtask

   // Monitor: scoreboard on upd_done, plus framing and period tracking
   initial begin
      int  hi_run, lo_run, since_ud;
      bit  prev_cmp, lo_ok, ud_ok;
      logic [WL*N-1:0] e;
      hi_run = 0; lo_run = 0; since_ud = 0;
      prev_cmp = 1'b0; lo_ok = 1'b0; ud_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hi_run = 0; lo_run = 0; since_ud = 0;
            prev_cmp = 1'b0; lo_ok = 1'b0; ud_ok = 1'b0;
         end else begin
            if (bus_if.cmp_rst_b) begin
               if (!prev_cmp && lo_ok) chk("cmp_rst_b low run", lo_run, 1 + N);
               chk("busy during window", int'(bus_if.busy), 1);
               hi_run++; lo_run = 0; lo_ok = 1'b0;
            end else begin
               if (prev_cmp) begin
                  chk("cmp_rst_b high run", hi_run, GL);
                  lo_ok = 1'b1;
               end
               hi_run = 0; lo_run++;
               if (!bus_if.busy) lo_ok = 1'b0;
            end
            prev_cmp = bus_if.cmp_rst_b;

            since_ud++;
            if (bus_if.upd_done) begin
               if (ud_ok) chk("upd_done period", since_ud, GL + 1 + N);
               since_ud = 0;
               ud_ok = bus_if.busy;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected upd_done: got pulse expected none");
               end else begin
                  e = exp_q.pop_front();
                  chk("weights at upd_done", int'(bus_if.weights), int'(e));
               end
            end else if (!bus_if.busy) begin
               ud_ok = 1'b0;
            end
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      int v, busy_hi, c;
      v = 1;
      for (int k = 0; k < 127; k++) begin
         seq[k] = v;
         v = ((v << 1) & 7'h7E) | (((v >> 6) ^ (v >> 5)) & 1);
      end
      model_reset();
      clear_ev();
      rst = 1'b1;
      bus_if.run = 1'b0;
      bus_if.prob_in = '0;
      bus_if.inc_in = '0;
      #3;
      chk("reset busy", int'(bus_if.busy), 0);
      chk("reset cmp_rst_b", int'(bus_if.cmp_rst_b), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < N; i++) chk($sformatf("reset weight%0d", i), w_of(i), 4);
      chk("reset upd_done", int'(bus_if.upd_done), 0);

      // Idle with run low, comparator outputs toggling
      busy_hi = 0;
      for (int k = 0; k < 12; k++) begin
         bus_if.prob_in = 56'({$urandom, $urandom});
         bus_if.inc_in  = 8'($urandom);
         @(posedge clk); #1;
         if (bus_if.busy || bus_if.cmp_rst_b) busy_hi++;
      end
      chk("idle stays idle", busy_hi, 0);

      // Deterministic increment on synapse 2 in CLOSE
      clear_ev();
      ev_prob[GL][2] = 127; ev_inc[GL][2] = 1'b1;
      start_run();
      do_window(1'b0, -1);
      for (int i = 0; i < N; i++) chk($sformatf("det inc weight%0d", i), w_of(i), (i == 2) ? 5 : 4);

      // Framing with no events, back to back
      clear_ev();
      start_run();
      do_window(1'b1, -1);
      do_window(1'b1, -1);
      do_window(1'b0, -1);
      chk("no-event weight2", w_of(2), 5);

      // Saturation up then down on synapse 0
      clear_ev();
      ev_prob[GL][0] = 127; ev_inc[GL][0] = 1'b1;
      start_run();
      for (int k = 0; k < 5; k++) do_window(k < 4, -1);
      chk("saturate high weight0", w_of(0), 7);
      ev_inc[GL][0] = 1'b0;
      start_run();
      for (int k = 0; k < 10; k++) do_window(k < 9, -1);
      chk("saturate low weight0", w_of(0), 0);

      // Reset in the middle of UPDATE
      clear_ev();
      ev_prob[4][3] = 127; ev_inc[4][3] = 1'b1;
      start_run();
      do_window(1'b0, 3);
      @(posedge clk); #1;
      chk("post-reset busy", int'(bus_if.busy), 0);

      // First event wins on synapse 1
      clear_ev();
      ev_prob[3][1] = 127; ev_inc[3][1] = 1'b0;
      ev_prob[GL][1] = 127; ev_inc[GL][1] = 1'b1;
      start_run();
      do_window(1'b0, -1);
      chk("first-event weight1", w_of(1), 3);

      // Randomized windows; synapse 5 at prob 64, steered to stay mid-range
      start_run();
      for (int n = 0; n < 127; n++) begin
         clear_ev();
         c = $urandom_range(0, GL);
         ev_prob[c][5] = 64;
         ev_inc[c][5]  = (m_w[5] < 4);
         for (int i = 0; i < N; i++) begin
            if (i != 5) begin
               for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                  c = $urandom_range(0, GL);
                  ev_prob[c][i] = $urandom_range(0, 127);
                  ev_inc[c][i]  = 1'($urandom_range(0, 1));
               end
            end
         end
         do_window(n < 126, -1);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard drained", exp_q.size(), 0);
      chk("final idle", int'(bus_if.busy), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
